oled_frame_streamer: RTL and testbench
======================================

OLED_FRAME_STREAMER -- requirements
Module: oled_frame_streamer

Interface
REQ-001 SHALL have parameter STARTUP_WAIT, default 32'd10000000, clk cycles spent in each of the three power-up reset phases.
REQ-002 SHALL have parameter SCLK_DIV, default 8'd1, clk cycles per sclk half-period (legal range 1..255).
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 resetn  input  1  asynchronous, active-low reset; no other clock or reset exists.
REQ-005 pixelAddress  output  10  byte index 0..1023 into the text engine's 128x64 page-mode frame.
REQ-006 pixelData  input  8  frame byte for pixelAddress, valid one clk after the address changes (registered source).
REQ-007 sclk  output  1  SPI clock to panel, idle low (mode 0).
REQ-008 sdin  output  1  SPI data to panel, MSB first.
REQ-009 cs  output  1  panel chip select, active low.
REQ-010 dc  output  1  0 = command byte, 1 = display-data byte.
REQ-011 oledReset  output  1  panel reset, active low.
REQ-012 frameDone  output  1  one-clk pulse after the last data byte of a frame completes.

Function
REQ-013 SHALL implement states POWER_HIGH, POWER_LOW, POWER_WAIT, LOAD_CMD, LOAD_DATA, SEND, NEXT, IDLE.
REQ-014 POWER_HIGH: oledReset=1 for STARTUP_WAIT clks; POWER_LOW: oledReset=0 for STARTUP_WAIT clks; POWER_WAIT: oledReset=1 for STARTUP_WAIT clks, then LOAD_CMD.
REQ-015 Command ROM SHALL hold exactly 15 bytes, sent in order with dc=0: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 AF.
REQ-016 After command byte 14, SHALL enter LOAD_DATA with pixelAddress=0 and dc=1.
REQ-017 LOAD_DATA SHALL hold pixelAddress stable 2 clks and latch pixelData on the second clk into the shift register.
REQ-018 SEND: cs=0 for the whole byte; sdin updated only while sclk=0; each of 8 bits = SCLK_DIV clks low then SCLK_DIV clks high; sclk returns low after bit 0.
REQ-019 NEXT: cs=1 for exactly 1 clk between bytes; then next command, next pixelAddress+1, or frame end.
REQ-020 Byte period SHALL be 2 (load) + 16*SCLK_DIV (send) + 1 (next) clks for data bytes.
REQ-021 pixelAddress SHALL increment by 1 per data byte; after byte 1023 it wraps to 0 and frameDone pulses in that same NEXT cycle.
REQ-022 Init sequence and power-up SHALL run once per reset only; frames never resend commands.

Reset
REQ-023 On resetn=0, immediately (asynchronously): state=POWER_HIGH, counters=0, pixelAddress=0, sclk=0, sdin=0, cs=1, dc=0, oledReset=1, frameDone=0.
REQ-024 Reset asserted mid-byte or mid-frame SHALL abort with no partial sclk edge after assertion; sequence restarts from POWER_HIGH on release.
REQ-025 Reset release SHALL be synchronised internally; first state advance occurs on the 2nd posedge after deassertion.

Configuration
REQ-026 Macro OLED_CONTINUOUS_REFRESH_EN defined: after frameDone, SHALL return to LOAD_DATA at pixelAddress=0 and stream frames indefinitely.
REQ-027 Macro OLED_CONTINUOUS_REFRESH_EN undefined: after the first frameDone, SHALL enter IDLE holding cs=1, sclk=0, pixelAddress=0 until reset.

Verification
REQ-028 STARTUP_WAIT=4, reset release -> oledReset 1 for 4 clks, 0 for 4 clks, 1 thereafter; cs stays 1 through those 12 clks.
REQ-029 STARTUP_WAIT=4, SCLK_DIV=1 -> decoded SPI stream with dc=0 equals the 15-byte ROM exactly, each byte 8 sclk rises, cs high 1 clk between bytes.
REQ-030 Model pixelData = pixelAddress[7:0] with 1-clk latency -> data bytes 00,01,..,FF,00,.. captured on sclk rises, 1024 bytes with dc=1, frameDone one pulse after byte 1023.
REQ-031 SCLK_DIV=3 -> sclk high and low each exactly 3 clks; data byte period 51 clks.
REQ-032 resetn pulsed low during data byte 500 -> outputs at reset values within the same cycle; power-up restarts; next data stream begins at pixelAddress 0.
REQ-033 With and without OLED_CONTINUOUS_REFRESH_EN, run 2.5 frame times -> defined: 2 frameDone pulses, streaming continues; undefined: 1 pulse, then cs=1, no sclk activity.

Source files
------------

// File: rtl/oled_frame_streamer_if.sv
// Panel-side bundle for oled_frame_streamer: the SPI pins, the panel reset,
// the frame-buffer fetch bus and the end-of-frame strobe.
// The master modport is the streamer; the slave modport is the panel/frame-buffer side.
interface oled_frame_streamer_if;
    logic [9:0] pixelAddress;
    logic [7:0] pixelData;
    logic       sclk;
    logic       sdin;
    logic       cs;
    logic       dc;
    logic       oledReset;
    logic       frameDone;

    modport master (
        output pixelAddress, sclk, sdin, cs, dc, oledReset, frameDone,
        input  pixelData
    );

    modport slave (
        input  pixelAddress, sclk, sdin, cs, dc, oledReset, frameDone,
        output pixelData
    );
endinterface

// File: rtl/oled_frame_streamer.sv
// oled_frame_streamer: powers up a 128x64 SSD1306-style panel, sends the
// fixed 15-byte init sequence, then streams the 1024-byte page-mode frame
// over mode-0 SPI (MSB first).
// Optional macro OLED_CONTINUOUS_REFRESH_EN: when defined, frames repeat
// forever; when undefined, the streamer parks in IDLE after one frame.
module oled_frame_streamer #(
    parameter logic [31:0] STARTUP_WAIT = 32'd10000000,
    parameter logic [7:0]  SCLK_DIV     = 8'd1
) (
    input  logic                  clk,
    input  logic                  resetn,
    oled_frame_streamer_if.master oled
);

    typedef enum logic [2:0] {
        POWER_HIGH,
        POWER_LOW,
        POWER_WAIT,
        LOAD_CMD,
        LOAD_DATA,
        SEND,
        NEXT,
        IDLE
    } state_t;

    state_t      state, stateNext;
    logic        runEn;
    logic [31:0] powerCnt, powerCntNext;
    logic [3:0]  cmdIdx, cmdIdxNext;
    logic [9:0]  pixelAddr, pixelAddrNext;
    logic [7:0]  shiftReg, shiftNext;
    logic [2:0]  bitCnt, bitCntNext;
    logic [7:0]  divCnt, divCntNext;
    logic        sclkReg, sclkNext;
    logic        dcReg, dcNext;
    logic        loadPhase, loadPhaseNext;

    function automatic logic [7:0] cmdRom(input logic [3:0] idx);
        case (idx)
            4'd0:    cmdRom = 8'hAE;  // display off
            4'd1:    cmdRom = 8'hD5;  // clock divide
            4'd2:    cmdRom = 8'h80;
            4'd3:    cmdRom = 8'hA8;  // multiplex ratio
            4'd4:    cmdRom = 8'h3F;
            4'd5:    cmdRom = 8'hD3;  // display offset
            4'd6:    cmdRom = 8'h00;
            4'd7:    cmdRom = 8'h40;  // start line 0
            4'd8:    cmdRom = 8'h8D;  // charge pump
            4'd9:    cmdRom = 8'h14;
            4'd10:   cmdRom = 8'h20;  // addressing mode
            4'd11:   cmdRom = 8'h00;
            4'd12:   cmdRom = 8'hA1;  // segment remap
            4'd13:   cmdRom = 8'hC8;  // COM scan direction
            4'd14:   cmdRom = 8'hAF;  // display on
            default: cmdRom = 8'h00;
        endcase
    endfunction

    // Reset release synchroniser: assertion is immediate, release reaches the
    // FSM one edge later so the first advance happens on the 2nd posedge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) runEn <= 1'b0;
        else         runEn <= 1'b1;
    end

    // State and datapath registers, all cleared asynchronously so a reset
    // mid-byte drops sclk/cs immediately with no partial edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= POWER_HIGH;
            powerCnt  <= '0;
            cmdIdx    <= '0;
            pixelAddr <= '0;
            shiftReg  <= '0;
            bitCnt    <= '0;
            divCnt    <= '0;
            sclkReg   <= 1'b0;
            dcReg     <= 1'b0;
            loadPhase <= 1'b0;
        end else begin
            state     <= stateNext;
            powerCnt  <= powerCntNext;
            cmdIdx    <= cmdIdxNext;
            pixelAddr <= pixelAddrNext;
            shiftReg  <= shiftNext;
            bitCnt    <= bitCntNext;
            divCnt    <= divCntNext;
            sclkReg   <= sclkNext;
            dcReg     <= dcNext;
            loadPhase <= loadPhaseNext;
        end
    end

    // Next-state and datapath updates for power-up, init commands and frame streaming.
    always_comb begin
        stateNext     = state;
        powerCntNext  = powerCnt;
        cmdIdxNext    = cmdIdx;
        pixelAddrNext = pixelAddr;
        shiftNext     = shiftReg;
        bitCntNext    = bitCnt;
        divCntNext    = divCnt;
        sclkNext      = sclkReg;
        dcNext        = dcReg;
        loadPhaseNext = loadPhase;
        if (runEn) begin
            case (state)
                POWER_HIGH, POWER_LOW, POWER_WAIT: begin
                    if (powerCnt == STARTUP_WAIT - 32'd1) begin
                        powerCntNext = '0;
                        if (state == POWER_HIGH)     stateNext = POWER_LOW;
                        else if (state == POWER_LOW) stateNext = POWER_WAIT;
                        else                         stateNext = LOAD_CMD;
                    end else begin
                        powerCntNext = powerCnt + 32'd1;
                    end
                end
                LOAD_CMD: begin
                    shiftNext  = cmdRom(cmdIdx);
                    bitCntNext = '0;
                    divCntNext = '0;
                    stateNext  = SEND;
                end
                LOAD_DATA: begin
                    // First clk presents the address; the registered source
                    // answers one clk later, so capture on the second.
                    if (!loadPhase) begin
                        loadPhaseNext = 1'b1;
                    end else begin
                        loadPhaseNext = 1'b0;
                        shiftNext     = oled.pixelData;
                        bitCntNext    = '0;
                        divCntNext    = '0;
                        stateNext     = SEND;
                    end
                end
                SEND: begin
                    if (divCnt == SCLK_DIV - 8'd1) begin
                        divCntNext = '0;
                        if (!sclkReg) begin
                            sclkNext = 1'b1;
                        end else begin
                            // Shift on the falling edge so sdin only moves while sclk is low.
                            sclkNext   = 1'b0;
                            shiftNext  = {shiftReg[6:0], 1'b0};
                            bitCntNext = bitCnt + 3'd1;
                            if (bitCnt == 3'd7) stateNext = NEXT;
                        end
                    end else begin
                        divCntNext = divCnt + 8'd1;
                    end
                end
                NEXT: begin
                    if (!dcReg) begin
                        if (cmdIdx == 4'd14) begin
                            dcNext        = 1'b1;
                            pixelAddrNext = '0;
                            stateNext     = LOAD_DATA;
                        end else begin
                            cmdIdxNext = cmdIdx + 4'd1;
                            stateNext  = LOAD_CMD;
                        end
                    end else if (pixelAddr == 10'd1023) begin
                        pixelAddrNext = '0;
`ifdef OLED_CONTINUOUS_REFRESH_EN
                        stateNext = LOAD_DATA;
`else
                        stateNext = IDLE;
`endif
                    end else begin
                        pixelAddrNext = pixelAddr + 10'd1;
                        stateNext     = LOAD_DATA;
                    end
                end
                IDLE: begin
                    stateNext = IDLE;
                end
                default: begin
                    stateNext = POWER_HIGH;
                end
            endcase
        end
    end

    // cs is low from byte load through the last sclk fall; high only in
    // power-up, the 1-clk NEXT gap and IDLE.
    assign oled.cs           = !((state == LOAD_CMD) || (state == LOAD_DATA) || (state == SEND));
    assign oled.sclk         = sclkReg;
    assign oled.sdin         = shiftReg[7];
    assign oled.dc           = dcReg;
    assign oled.oledReset    = (state != POWER_LOW);
    assign oled.pixelAddress = pixelAddr;
    assign oled.frameDone    = (state == NEXT) && dcReg && (pixelAddr == 10'd1023);

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Bench for oled_frame_streamer: two instances (SCLK_DIV=1 and SCLK_DIV=3,
// STARTUP_WAIT=4) with SPI decoders, directed sequences and a pixel source
// that returns pixelAddress[7:0] one clk later.
module tb_oled_frame_streamer;

    logic clk     = 1'b0;
    logic resetn  = 1'b1;
    logic resetn3 = 1'b1;
    int   checks  = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    oled_frame_streamer_if o1 ();
    oled_frame_streamer_if o3 ();

    oled_frame_streamer #(.STARTUP_WAIT(32'd4), .SCLK_DIV(8'd1)) dut1 (
        .clk(clk), .resetn(resetn), .oled(o1)
    );
    oled_frame_streamer #(.STARTUP_WAIT(32'd4), .SCLK_DIV(8'd3)) dut3 (
        .clk(clk), .resetn(resetn3), .oled(o3)
    );

    // Registered frame-buffer model
    always @(posedge clk) begin
        o1.pixelData <= o1.pixelAddress[7:0];
        o3.pixelData <= o3.pixelAddress[7:0];
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Decoder for the SCLK_DIV=1 instance
    logic       prevSclk1, prevSdin1, prevCs1, prevFd1;
    logic [7:0] sh1;
    logic [7:0] cmdQ [$];
    logic [7:0] dataLog [0:1023];
    int bits1, dataCnt1, dataErr1, rises1, fdCount1, fdWidthBad1, dataCntAtFd1;
    int gapBad1, csHiRun1, framingErr1, sdinErr1, csSclkErr1;
    bit csArmed1;

    always @(negedge clk) begin
        if (!resetn) begin
            bits1 = 0; dataCnt1 = 0; dataErr1 = 0; rises1 = 0; fdCount1 = 0;
            fdWidthBad1 = 0; dataCntAtFd1 = -1; gapBad1 = 0; csHiRun1 = 0;
            framingErr1 = 0; sdinErr1 = 0; csSclkErr1 = 0; csArmed1 = 0;
            prevFd1 = 0; prevSclk1 = 0; prevSdin1 = 0; prevCs1 = 1; sh1 = 0;
            cmdQ.delete();
        end else begin
            if (o1.sclk && !prevSclk1) begin
                rises1++;
                if (o1.cs) csSclkErr1++;
                sh1 = {sh1[6:0], o1.sdin};
                bits1++;
                if (bits1 == 8) begin
                    bits1 = 0;
                    if (!o1.dc) cmdQ.push_back(sh1);
                    else begin
                        if (dataCnt1 < 1024) dataLog[dataCnt1[9:0]] = sh1;
                        if (sh1 != dataCnt1[7:0]) dataErr1++;
                        dataCnt1++;
                    end
                end
            end
            if (o1.sclk && prevSclk1 && (o1.sdin != prevSdin1)) sdinErr1++;
            if (o1.cs) csHiRun1++;
            else begin
                if (prevCs1) begin
                    if (csArmed1 && csHiRun1 != 1) gapBad1++;
                    csArmed1 = 1;
                end
                csHiRun1 = 0;
            end
            if (o1.cs && !prevCs1 && bits1 != 0) framingErr1++;
            if (o1.frameDone) begin
                if (prevFd1) fdWidthBad1++;
                else begin
                    fdCount1++;
                    if (fdCount1 == 1) dataCntAtFd1 = dataCnt1;
                end
            end
            prevFd1 = o1.frameDone; prevSclk1 = o1.sclk;
            prevSdin1 = o1.sdin; prevCs1 = o1.cs;
        end
    end

    // Timing decoder for the SCLK_DIV=3 instance
    logic       prevSclk3, prevCs3;
    logic [7:0] sh3;
    int bits3, dataCnt3, dataErr3, cmdCnt3, run3, hiCnt3, hiBad3, loCnt3, loBad3;
    int perCnt3, perBad3, lastRise3;
    bit seenHi3;

    always @(negedge clk) begin
        if (!resetn3) begin
            bits3 = 0; dataCnt3 = 0; dataErr3 = 0; cmdCnt3 = 0; run3 = 0;
            hiCnt3 = 0; hiBad3 = 0; loCnt3 = 0; loBad3 = 0; perCnt3 = 0;
            perBad3 = 0; lastRise3 = -1; seenHi3 = 0; prevSclk3 = 0; prevCs3 = 1; sh3 = 0;
        end else begin
            if (o3.sclk && !prevSclk3) begin
                sh3 = {sh3[6:0], o3.sdin};
                bits3++;
                if (bits3 == 8) begin
                    bits3 = 0;
                    if (o3.dc) begin
                        if (sh3 != dataCnt3[7:0]) dataErr3++;
                        dataCnt3++;
                    end else cmdCnt3++;
                end
            end
            if (o3.sclk != prevSclk3) begin
                if (prevSclk3) begin
                    hiCnt3++;
                    if (run3 != 3) hiBad3++;
                    seenHi3 = 1;
                end else if (seenHi3) begin
                    loCnt3++;
                    if (run3 != 3) loBad3++;
                end
                run3 = 1;
            end else run3++;
            if (o3.cs) seenHi3 = 0;
            if (o3.cs && !prevCs3 && o3.dc) begin
                if (lastRise3 >= 0) begin
                    perCnt3++;
                    if (cyc - lastRise3 != 51) perBad3++;
                end
                lastRise3 = cyc;
            end
            prevSclk3 = o3.sclk; prevCs3 = o3.cs;
        end
    end

    int romExp [15] = '{32'hAE, 32'hD5, 32'h80, 32'hA8, 32'h3F, 32'hD3, 32'h00, 32'h40,
                        32'h8D, 32'h14, 32'h20, 32'h00, 32'hA1, 32'hC8, 32'hAF};

    initial begin
        int waitCnt;
        int rises0;
        int hiSeen;
        logic [15:0] orVec;
        logic [15:0] csVec;

        // Asynchronous reset values
        #2 resetn = 1'b0; resetn3 = 1'b0;
        #1;
        checkVal("rst_oledReset", 32'(o1.oledReset), 1);
        checkVal("rst_cs", 32'(o1.cs), 1);
        checkVal("rst_sclk", 32'(o1.sclk), 0);
        checkVal("rst_sdin", 32'(o1.sdin), 0);
        checkVal("rst_dc", 32'(o1.dc), 0);
        checkVal("rst_frameDone", 32'(o1.frameDone), 0);
        checkVal("rst_pixelAddress", 32'(o1.pixelAddress), 0);
        checkVal("rst3_cs", 32'(o3.cs), 1);

        repeat (2) @(negedge clk);
        resetn = 1'b1; resetn3 = 1'b1;

        // Power-up: 4 high, 4 low, 4 high, then first command load (cs low)
        orVec = '0; csVec = '0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            orVec[k] = o1.oledReset;
            csVec[k] = o1.cs;
        end
        checkVal("powerup_oledReset_seq", 32'(orVec), 32'h7E1E);
        checkVal("powerup_cs_seq", 32'(csVec), 32'h1FFE);

        // Init command stream
        waitCnt = 0;
        while (cmdQ.size() < 15 && waitCnt < 2000) begin @(negedge clk); waitCnt++; end
        checkVal("cmd_count", 32'(cmdQ.size()), 15);
        for (int i = 0; i < 15; i++)
            if (i < cmdQ.size()) checkVal($sformatf("cmd_byte%0d", i), 32'(cmdQ[i]), 32'(romExp[i]));

        // SCLK_DIV=3 timing
        waitCnt = 0;
        while (perCnt3 < 5 && waitCnt < 4000) begin @(negedge clk); waitCnt++; end
        checkVal("div3_periods_seen", 32'(perCnt3 >= 5), 1);
        checkVal("div3_period_bad", 32'(perBad3), 0);
        checkVal("div3_high_seen", 32'(hiCnt3 > 100), 1);
        checkVal("div3_high_bad", 32'(hiBad3), 0);
        checkVal("div3_low_seen", 32'(loCnt3 > 100), 1);
        checkVal("div3_low_bad", 32'(loBad3), 0);
        checkVal("div3_cmd_count", 32'(cmdCnt3), 15);
        checkVal("div3_data_err", 32'(dataErr3), 0);

        // First full frame
        waitCnt = 0;
        while (fdCount1 < 1 && waitCnt < 25000) begin @(negedge clk); waitCnt++; end
        checkVal("frame1_done", 32'(fdCount1), 1);
        checkVal("bytes_at_frameDone", 32'(dataCntAtFd1), 1024);
        checkVal("data_err", 32'(dataErr1), 0);
        checkVal("data0", 32'(dataLog[0]), 32'h00);
        checkVal("data1", 32'(dataLog[1]), 32'h01);
        checkVal("data255", 32'(dataLog[255]), 32'hFF);
        checkVal("data256", 32'(dataLog[256]), 32'h00);
        checkVal("data1023", 32'(dataLog[1023]), 32'hFF);
        checkVal("frameDone_width_bad", 32'(fdWidthBad1), 0);
        checkVal("cs_gap_bad", 32'(gapBad1), 0);
        checkVal("byte_framing_bad", 32'(framingErr1), 0);
        checkVal("sdin_change_while_sclk_high", 32'(sdinErr1), 0);
        checkVal("sclk_rise_with_cs_high", 32'(csSclkErr1), 0);
        @(negedge clk);
        checkVal("addr_wrapped", 32'(o1.pixelAddress), 0);

        // Another 1.5 frame times
        rises0 = rises1;
        repeat (29200) @(negedge clk);
`ifdef OLED_CONTINUOUS_REFRESH_EN
        checkVal("frames_in_2p5", 32'(fdCount1), 2);
        checkVal("still_streaming", 32'((rises1 - rises0) > 0), 1);
        checkVal("data_err_multi", 32'(dataErr1), 0);
        checkVal("frameDone_width_bad2", 32'(fdWidthBad1), 0);
`else
        checkVal("frames_in_2p5", 32'(fdCount1), 1);
        checkVal("idle_sclk_rises", 32'(rises1 - rises0), 0);
        checkVal("idle_cs", 32'(o1.cs), 1);
        checkVal("idle_sclk", 32'(o1.sclk), 0);
        checkVal("idle_addr", 32'(o1.pixelAddress), 0);
`endif

        // Restart, then reset in the middle of data byte 500
        @(negedge clk); resetn = 1'b0;
        repeat (2) @(negedge clk); resetn = 1'b1;
        waitCnt = 0;
        while (!(o1.pixelAddress == 10'd500 && o1.sclk && o1.dc) && waitCnt < 12000) begin
            @(negedge clk); waitCnt++;
        end
        checkVal("byte500_reached", 32'(o1.pixelAddress), 500);
        checkVal("bytes_before_500", 32'(dataCnt1), 500);
        resetn = 1'b0;
        #1;
        checkVal("midrst_sclk", 32'(o1.sclk), 0);
        checkVal("midrst_cs", 32'(o1.cs), 1);
        checkVal("midrst_addr", 32'(o1.pixelAddress), 0);
        checkVal("midrst_dc", 32'(o1.dc), 0);
        checkVal("midrst_sdin", 32'(o1.sdin), 0);
        checkVal("midrst_oledReset", 32'(o1.oledReset), 1);
        hiSeen = 0;
        repeat (3) begin
            @(negedge clk);
            if (o1.sclk || !o1.cs) hiSeen++;
        end
        checkVal("midrst_held_idle", 32'(hiSeen), 0);
        resetn = 1'b1;
        waitCnt = 0;
        while (dataCnt1 < 3 && waitCnt < 2000) begin @(negedge clk); waitCnt++; end
        checkVal("restart_cmd_count", 32'(cmdQ.size()), 15);
        checkVal("restart_data_count", 32'(dataCnt1 >= 3), 1);
        checkVal("restart_data0", 32'(dataLog[0]), 32'h00);
        checkVal("restart_data1", 32'(dataLog[1]), 32'h01);
        checkVal("restart_data2", 32'(dataLog[2]), 32'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
